mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported, waitrequest-style memory between the processor's instruction-fetch port and its data port (load/store).
- Sits between the 5-stage pipelined processor and the unified memory.
- Presents an independent Waitreq to each requester, so Fetch and Memory stages stall until their access completes.
- Data accesses have priority, with a starvation guard for fetch.

Parameters:
WORD_SIZE, 16, data and address width in bits (shared package constant)
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced next
CNT_BITS, $clog2(STARVE_LIMIT+1), width of the starvation counter

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous, active-low reset
InstrAddr  in  WORD_SIZE  fetch address
InstrRead  in  1  fetch request
InstrIn  out  WORD_SIZE  fetch read data
InstrWaitreq  out  1  fetch not complete this cycle
DataAddr  in  WORD_SIZE  load/store address
DataOut  in  WORD_SIZE  store data
ReadData  in  1  load request
WriteData  in  1  store request
DataIn  out  WORD_SIZE  load read data
DataWaitreq  out  1  data access not complete this cycle
MemAddr  out  WORD_SIZE  memory address
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
MemWdata  out  WORD_SIZE  memory write data
MemRdata  in  WORD_SIZE  memory read data, valid when the read strobe is high and MemWaitreq is 0
MemWaitreq  in  1  memory stall
ErrConflict  out  1  sticky: ReadData and WriteData were asserted together

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports Clock, Resetn).
- State machine (registered): IDLE, GNT_INSTR, GNT_DATA. Reset → IDLE, starvation counter 0, ErrConflict 0.
- IDLE:
  - No memory strobes are driven.
  - Data request (ReadData|WriteData) with counter < STARVE_LIMIT → GNT_DATA.
  - Otherwise, if InstrRead → GNT_INSTR.
  - Otherwise, if a data request is present → GNT_DATA.
  - Otherwise stay in IDLE.
  - This gives a 1-cycle arbitration latency.
- GNT_INSTR:
  - MemAddr=InstrAddr, MemRead=1, MemWrite=0.
  - Completion cycle = MemWaitreq==0: InstrWaitreq=0, InstrIn=MemRdata, counter cleared, next state IDLE.
- GNT_DATA:
  - MemAddr=DataAddr.
  - WriteData=1: MemWrite=1, MemWdata=DataOut.
  - Otherwise: MemRead=1.
  - Completion cycle: DataWaitreq=0, DataIn=MemRdata (reads only), next state IDLE.
  - At completion, if InstrRead=1, counter increments, saturating at STARVE_LIMIT.
- Waitreq outputs are combinational and equal 1 in every cycle except a completion cycle for that port. This includes reset, IDLE, and the other port's grant.
- Requesters hold address, data and strobes stable until their Waitreq is 0; the arbiter does not latch them.
- If a requester drops its request mid-grant: strobes follow the live inputs. Once no strobe is active for the granted port, return to IDLE next cycle with no completion and no counter change.
- ReadData and WriteData both high: treated as a write, and ErrConflict is set (sticky until reset).
- Reset mid-grant: strobes drop immediately (asynchronously). The outstanding access is abandoned.
- Outputs while not driven: MemAddr, MemWdata, InstrIn and DataIn are 0 whenever their strobe or completion is inactive (no stale data).
- Throughput: at most one access per 2 cycles. A zero-wait access occupies 1 arbitration cycle plus 1 grant cycle.

Decomposition:
- Shared package: WORD_SIZE, and the arbiter state enum {IDLE, GNT_INSTR, GNT_DATA} next to the existing Stages/Instr enums.
- One natural sub-module: arb_starve_counter (saturating counter with clear and increment enable).

Test Plan:
1. Fetch only, MemWaitreq=0, InstrAddr=0x0010, MemRdata=0xA5A5 → MemRead high in cycle 2; InstrWaitreq=0 with InstrIn=0xA5A5 in cycle 2.
2. Simultaneous ReadData (addr 0x0200) and InstrRead (addr 0x0001) → data granted first, fetch granted in the next arbitration; DataIn correct; counter ends at 0.
3. Continuous loads with fetch pending, STARVE_LIMIT=4 → exactly 4 data completions, then a fetch grant, then data resumes.
4. Store DataOut=0x1234 to 0x0040 with MemWaitreq=1 for 3 cycles → MemWrite held 3+1 cycles, DataWaitreq=0 only on the final cycle, MemWdata=0x1234 throughout.
5. Resetn pulsed low mid-GNT_DATA → MemRead/MemWrite 0 within the same cycle; state IDLE; both Waitreq outputs 1.
6. ReadData=WriteData=1 → write performed, ErrConflict=1, still 1 after requests drop until reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared processor constants and enums, plus the memory-port arbiter state type.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [2:0] {
        STAGE_IF,
        STAGE_ID,
        STAGE_EX,
        STAGE_MEM,
        STAGE_WB
    } stages_t;

    typedef enum logic [3:0] {
        INSTR_ADD,
        INSTR_SUB,
        INSTR_AND,
        INSTR_OR,
        INSTR_LD,
        INSTR_ST,
        INSTR_BEQ,
        INSTR_JMP,
        INSTR_NOP
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        GNT_INSTR,
        GNT_DATA
    } arb_state_t;

    function automatic logic is_data_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants completed while a fetch was left waiting.
module arb_starve_counter #(
    parameter int LIMIT    = 4,
    parameter int CNT_BITS = $clog2(LIMIT + 1)
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                clr,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < CNT_BITS'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one waitrequest-style memory between the fetch port and the load/store port.
// Data has priority; a saturating counter forces a fetch after STARVE_LIMIT data grants.
//
// state     | meaning
// IDLE      | arbitration cycle, no memory strobes
// GNT_INSTR | fetch owns the memory until MemWaitreq drops or InstrRead is withdrawn
// GNT_DATA  | load/store owns the memory until MemWaitreq drops or the request is withdrawn
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_BITS     = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    input  logic                 InstrRead,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrWaitreq,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [WORD_SIZE-1:0] MemWdata,
    input  logic [WORD_SIZE-1:0] MemRdata,
    input  logic                 MemWaitreq,
    output logic                 ErrConflict
);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [CNT_BITS-1:0] starve_cnt;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                data_req;
    logic                starve_ok;
    logic                err_conflict;

    assign data_req    = is_data_req(ReadData, WriteData);
    assign starve_ok   = (starve_cnt < CNT_BITS'(STARVE_LIMIT));
    assign ErrConflict = err_conflict;

    arb_starve_counter #(
        .LIMIT    (STARVE_LIMIT),
        .CNT_BITS (CNT_BITS)
    ) u_starve_counter (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (starve_cnt)
    );

    // Async reset of the state register is what drops the strobes immediately.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            err_conflict <= 1'b0;
        end else if (ReadData && WriteData) begin
            err_conflict <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_req && starve_ok) begin
                    state_nxt = GNT_DATA;
                end else if (InstrRead) begin
                    state_nxt = GNT_INSTR;
                end else if (data_req) begin
                    state_nxt = GNT_DATA;
                end
            end
            GNT_INSTR: begin
                if (!InstrRead || !MemWaitreq) begin
                    state_nxt = IDLE;
                end
            end
            GNT_DATA: begin
                if (!data_req || !MemWaitreq) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes follow the live request inputs; a withdrawn request gives no completion.
    always_comb begin
        MemAddr      = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemWdata     = '0;
        InstrIn      = '0;
        DataIn       = '0;
        InstrWaitreq = 1'b1;
        DataWaitreq  = 1'b1;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        case (state)
            GNT_INSTR: begin
                if (InstrRead) begin
                    MemAddr = InstrAddr;
                    MemRead = 1'b1;
                    if (!MemWaitreq) begin
                        InstrWaitreq = 1'b0;
                        InstrIn      = MemRdata;
                        cnt_clr      = 1'b1;
                    end
                end
            end
            GNT_DATA: begin
                if (data_req) begin
                    MemAddr = DataAddr;
                    if (WriteData) begin
                        MemWrite = 1'b1;
                        MemWdata = DataOut;
                    end else begin
                        MemRead = 1'b1;
                    end
                    if (!MemWaitreq) begin
                        DataWaitreq = 1'b0;
                        cnt_inc     = InstrRead;
                        if (!WriteData) begin
                            DataIn = MemRdata;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle checks followed by randomized traffic against a behavioural memory model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic                 Clock = 1'b0;
    logic                 Resetn;
    logic [WORD_SIZE-1:0] InstrAddr;
    logic                 InstrRead;
    logic [WORD_SIZE-1:0] InstrIn;
    logic                 InstrWaitreq;
    logic [WORD_SIZE-1:0] DataAddr;
    logic [WORD_SIZE-1:0] DataOut;
    logic                 ReadData;
    logic                 WriteData;
    logic [WORD_SIZE-1:0] DataIn;
    logic                 DataWaitreq;
    logic [WORD_SIZE-1:0] MemAddr;
    logic                 MemRead;
    logic                 MemWrite;
    logic [WORD_SIZE-1:0] MemWdata;
    logic [WORD_SIZE-1:0] MemRdata;
    logic                 MemWaitreq;
    logic                 ErrConflict;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .InstrAddr    (InstrAddr),
        .InstrRead    (InstrRead),
        .InstrIn      (InstrIn),
        .InstrWaitreq (InstrWaitreq),
        .DataAddr     (DataAddr),
        .DataOut      (DataOut),
        .ReadData     (ReadData),
        .WriteData    (WriteData),
        .DataIn       (DataIn),
        .DataWaitreq  (DataWaitreq),
        .MemAddr      (MemAddr),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemWdata     (MemWdata),
        .MemRdata     (MemRdata),
        .MemWaitreq   (MemWaitreq),
        .ErrConflict  (ErrConflict)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit                   wr;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] val;
    } req_t;

    int                   errors = 0;
    int                   checks = 0;
    logic [WORD_SIZE-1:0] mem     [256];
    logic [WORD_SIZE-1:0] ref_mem [256];
    logic [WORD_SIZE-1:0] junk = 16'hDEAD;
    req_t                 iq[$];
    req_t                 dq[$];
    bit                   sb_en = 1'b0;
    int                   dstreak = 0;

    // Environment memory: combinational read, write on the completion cycle.
    assign MemRdata = MemRead ? mem[MemAddr[7:0]] : junk;
    always @(posedge Clock) junk <= 16'($urandom);
    always @(negedge Clock) begin
        if (Resetn && MemWrite && !MemWaitreq) mem[MemAddr[7:0]] = MemWdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Scoreboard monitor plus protocol and starvation invariants.
    always @(negedge Clock) begin
        if (sb_en) begin
            req_t e;
            chk("strobe_excl", {31'd0, MemRead & MemWrite}, 32'd0);
            if (!MemRead && !MemWrite) chk("addr_idle_zero", 32'(MemAddr), 32'd0);
            if (!MemWrite) chk("wdata_idle_zero", 32'(MemWdata), 32'd0);
            if (InstrWaitreq) chk("instrin_zero", 32'(InstrIn), 32'd0);
            if (DataWaitreq) chk("datain_zero", 32'(DataIn), 32'd0);
            if (!InstrWaitreq) begin
                dstreak = 0;
                if (iq.size() == 0) begin
                    chk("fetch_unexpected", 32'd1, 32'd0);
                end else begin
                    e = iq.pop_front();
                    chk("fetch_memread", {31'd0, MemRead}, 32'd1);
                    chk("fetch_addr", 32'(MemAddr), 32'(e.addr));
                    chk("fetch_data", 32'(InstrIn), 32'(e.val));
                end
            end
            if (!DataWaitreq) begin
                if (InstrRead) dstreak++;
                if (dq.size() == 0) begin
                    chk("data_unexpected", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("data_addr", 32'(MemAddr), 32'(e.addr));
                    if (e.wr) begin
                        chk("store_memwrite", {31'd0, MemWrite}, 32'd1);
                        chk("store_wdata", 32'(MemWdata), 32'(e.val));
                        chk("store_datain_zero", 32'(DataIn), 32'd0);
                    end else begin
                        chk("load_memread", {31'd0, MemRead}, 32'd1);
                        chk("load_data", 32'(DataIn), 32'(e.val));
                    end
                end
                chk("starve_bound", {31'd0, dstreak > 4}, 32'd0);
            end
        end
    end

    int seq[$];
    int exp3[6] = '{0, 0, 0, 0, 1, 0};
    bit rnd_done;

    initial begin
        Resetn = 1'b0; InstrAddr = '0; InstrRead = 1'b0; DataAddr = '0; DataOut = '0;
        ReadData = 1'b0; WriteData = 1'b0; MemWaitreq = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'(i * 16'h0101) ^ 16'h3C3C;
            mem[i]     = ref_mem[i];
        end
        ref_mem[16'h10] = 16'hA5A5;
        mem[16'h10]     = 16'hA5A5;

        #3;
        chk("rst_instr_waitreq", {31'd0, InstrWaitreq}, 32'd1);
        chk("rst_data_waitreq", {31'd0, DataWaitreq}, 32'd1);
        chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("rst_err", {31'd0, ErrConflict}, 32'd0);
        repeat (2) cyc();
        Resetn = 1'b1;

        // 1: lone fetch, 1-cycle arbitration then zero-wait grant
        cyc();
        InstrAddr = 16'h0010; InstrRead = 1'b1;
        @(negedge Clock);
        chk("t1_c1_memread", {31'd0, MemRead}, 32'd0);
        chk("t1_c1_waitreq", {31'd0, InstrWaitreq}, 32'd1);
        @(negedge Clock);
        chk("t1_c2_memread", {31'd0, MemRead}, 32'd1);
        chk("t1_c2_addr", 32'(MemAddr), 32'h0010);
        chk("t1_c2_waitreq", {31'd0, InstrWaitreq}, 32'd0);
        chk("t1_c2_instrin", 32'(InstrIn), 32'hA5A5);
        cyc();
        InstrRead = 1'b0;
        @(negedge Clock);
        chk("t1_after_instrin", 32'(InstrIn), 32'd0);
        chk("t1_after_memread", {31'd0, MemRead}, 32'd0);

        // 2: simultaneous load and fetch, data wins first
        cyc();
        DataAddr = 16'h0200; ReadData = 1'b1; InstrAddr = 16'h0001; InstrRead = 1'b1;
        @(negedge Clock);
        chk("t2_c1_memread", {31'd0, MemRead}, 32'd0);
        @(negedge Clock);
        chk("t2_c2_addr", 32'(MemAddr), 32'h0200);
        chk("t2_c2_dwait", {31'd0, DataWaitreq}, 32'd0);
        chk("t2_c2_iwait", {31'd0, InstrWaitreq}, 32'd1);
        chk("t2_c2_datain", 32'(DataIn), 32'(ref_mem[8'h00]));
        cyc();
        ReadData = 1'b0;
        @(negedge Clock);
        chk("t2_c3_memread", {31'd0, MemRead}, 32'd0);
        @(negedge Clock);
        chk("t2_c4_addr", 32'(MemAddr), 32'h0001);
        chk("t2_c4_iwait", {31'd0, InstrWaitreq}, 32'd0);
        chk("t2_c4_instrin", 32'(InstrIn), 32'(ref_mem[8'h01]));
        cyc();
        InstrRead = 1'b0;
        chk("t2_counter", 32'(dut.starve_cnt), 32'd0);

        // 3: continuous loads with a pending fetch
        cyc();
        InstrAddr = 16'h0005; InstrRead = 1'b1; DataAddr = 16'h0041; ReadData = 1'b1;
        for (int i = 0; i < 40 && seq.size() < 6; i++) begin
            @(negedge Clock);
            if (!DataWaitreq) seq.push_back(0);
            if (!InstrWaitreq) seq.push_back(1);
        end
        chk("t3_count", 32'(seq.size()), 32'd6);
        for (int i = 0; i < 6 && i < seq.size(); i++) chk("t3_order", 32'(seq[i]), 32'(exp3[i]));
        cyc();
        InstrRead = 1'b0; ReadData = 1'b0;
        repeat (2) cyc();

        // 4: store stretched by three wait cycles
        DataAddr = 16'h0040; DataOut = 16'h1234; WriteData = 1'b1; MemWaitreq = 1'b1;
        ref_mem[8'h40] = 16'h1234;
        @(negedge Clock);
        chk("t4_c1_memwrite", {31'd0, MemWrite}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) MemWaitreq = 1'b0;
            @(negedge Clock);
            chk("t4_memwrite", {31'd0, MemWrite}, 32'd1);
            chk("t4_wdata", 32'(MemWdata), 32'h1234);
            chk("t4_addr", 32'(MemAddr), 32'h0040);
            chk("t4_dwait", {31'd0, DataWaitreq}, (i == 3) ? 32'd0 : 32'd1);
        end
        cyc();
        WriteData = 1'b0;
        cyc();

        // 5: reset asserted during a data grant
        DataAddr = 16'h0044; ReadData = 1'b1; MemWaitreq = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        chk("t5_granted", {31'd0, MemRead}, 32'd1);
        #2 Resetn = 1'b0;
        #1;
        chk("t5_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("t5_state", 32'(dut.state), 32'(IDLE));
        chk("t5_waitreqs", {30'd0, InstrWaitreq, DataWaitreq}, 32'd3);
        ReadData = 1'b0; MemWaitreq = 1'b0;
        cyc();
        Resetn = 1'b1;
        cyc();

        // 6: read and write together
        DataAddr = 16'h0048; DataOut = 16'hBEEF; ReadData = 1'b1; WriteData = 1'b1;
        ref_mem[8'h48] = 16'hBEEF;
        @(negedge Clock);
        @(negedge Clock);
        chk("t6_strobes", {30'd0, MemRead, MemWrite}, 32'd1);
        chk("t6_wdata", 32'(MemWdata), 32'hBEEF);
        chk("t6_dwait", {31'd0, DataWaitreq}, 32'd0);
        chk("t6_err", {31'd0, ErrConflict}, 32'd1);
        cyc();
        ReadData = 1'b0; WriteData = 1'b0;
        repeat (3) cyc();
        chk("t6_err_sticky", {31'd0, ErrConflict}, 32'd1);
        Resetn = 1'b0;
        #1;
        chk("t6_err_cleared", {31'd0, ErrConflict}, 32'd0);
        cyc();
        Resetn = 1'b1;
        cyc();

        // Randomized traffic on both ports with random memory stalls
        sb_en    = 1'b1;
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    cyc();
                    MemWaitreq = ($urandom_range(0, 2) == 0);
                end
                MemWaitreq = 1'b0;
            end
            begin
                fork
                    begin : fetch_proc
                        for (int n = 0; n < 60; n++) begin
                            int gap;
                            bit done;
                            gap = $urandom_range(0, 2);
                            repeat (gap) cyc();
                            InstrAddr = 16'($urandom_range(0, 63));
                            iq.push_back('{1'b0, InstrAddr, ref_mem[InstrAddr[7:0]]});
                            InstrRead = 1'b1;
                            done = 1'b0;
                            for (int c = 0; c < 200 && !done; c++) begin
                                @(negedge Clock);
                                if (!InstrWaitreq) done = 1'b1;
                            end
                            if (!done) chk("fetch_timeout", 32'd1, 32'd0);
                            cyc();
                            InstrRead = 1'b0;
                        end
                    end
                    begin : data_proc
                        for (int n = 0; n < 60; n++) begin
                            int gap;
                            bit done;
                            gap = $urandom_range(0, 2);
                            repeat (gap) cyc();
                            DataAddr = 16'h0040 + 16'($urandom_range(0, 15));
                            if ($urandom_range(0, 2) == 0) begin
                                DataOut = 16'($urandom);
                                ref_mem[DataAddr[7:0]] = DataOut;
                                dq.push_back('{1'b1, DataAddr, DataOut});
                                WriteData = 1'b1;
                            end else begin
                                dq.push_back('{1'b0, DataAddr, ref_mem[DataAddr[7:0]]});
                                ReadData = 1'b1;
                            end
                            done = 1'b0;
                            for (int c = 0; c < 200 && !done; c++) begin
                                @(negedge Clock);
                                if (!DataWaitreq) done = 1'b1;
                            end
                            if (!done) chk("data_timeout", 32'd1, 32'd0);
                            cyc();
                            ReadData = 1'b0; WriteData = 1'b0;
                        end
                    end
                join
                rnd_done = 1'b1;
            end
        join
        repeat (3) cyc();
        sb_en = 1'b0;
        chk("fetch_queue_empty", 32'(iq.size()), 32'd0);
        chk("data_queue_empty", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
